systolic_feeder: RTL and testbench

Host-side driver for the `MATRIX_SIZE`×`MATRIX_SIZE` systolic matrix multiplier. It latches two full matrices on `start` and streams them into the array as diagonally skewed row and column vectors. It controls the array's reset, waits for the array's `done`, and captures the product. The product is then presented to the consumer (the PCA covariance/projection stage) behind a valid/ready handshake.

---
 rtl/pca_pkg.sv | 8 +
 rtl/feeder_lane.sv | 18 +
 rtl/systolic_feeder.sv | 131 +++++++++++++
 tb/tb_systolic_feeder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pca_pkg.sv
// pca_pkg: shared types and constants for the PCA systolic datapath.
package pca_pkg;
    localparam int ARR_N = 4;
    localparam int ELEM_W = 8;
    localparam int FEED_LEN = 2 * ARR_N - 1;
    typedef logic [ELEM_W-1:0] elem_t;
    typedef enum logic [1:0] {IDLE, FEED, DRAIN, HOLD} feeder_state_t;
endpackage

// File: rtl/feeder_lane.sv
// feeder_lane: picks the diagonally skewed element of one row/column for step t.
module feeder_lane #(
    parameter int N = 4,
    parameter int W = 8,
    parameter int TW = 3
) (
    input  logic [TW-1:0] idx,
    input  logic [TW-1:0] t,
    input  logic [W-1:0]  vec [N],
    output logic [W-1:0]  elem
);
    localparam int IW = $clog2(N);
    logic [TW-1:0] k;
    always_comb begin
        k = t - idx;
        elem = (t >= idx && k < TW'(N)) ? vec[k[IW-1:0]] : '0;
    end
endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: latches A/B, streams skewed vectors into the array,
// waits for done and hands the product to the consumer over valid/ready.
module systolic_feeder import pca_pkg::*; #(
    parameter int MATRIX_SIZE = ARR_N,
    parameter int DATA_SIZE = ELEM_W,
    parameter int DONE_TIMEOUT = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [DATA_SIZE-1:0] mat_a [MATRIX_SIZE*MATRIX_SIZE],
    input  logic [DATA_SIZE-1:0] mat_b [MATRIX_SIZE*MATRIX_SIZE],
    output logic                 busy,
    output logic [DATA_SIZE-1:0] arr_a [MATRIX_SIZE],
    output logic [DATA_SIZE-1:0] arr_b [MATRIX_SIZE],
    output logic                 arr_reset,
    input  logic                 arr_done,
    input  logic [DATA_SIZE-1:0] arr_result [MATRIX_SIZE*MATRIX_SIZE],
    output logic [DATA_SIZE-1:0] result [MATRIX_SIZE*MATRIX_SIZE],
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic                 error
);
    localparam int N = MATRIX_SIZE;
    localparam int NN = N * N;
    localparam int TW = $clog2(2 * N);
    localparam int CW = $clog2(DONE_TIMEOUT + 1);

    feeder_state_t state, state_n;
    logic [TW-1:0] t, t_n;
    logic [CW-1:0] cnt, cnt_n;
    logic load, feed, cap, err_set;
    logic [DATA_SIZE-1:0] a_q [NN];
    logic [DATA_SIZE-1:0] b_q [NN];
    logic [DATA_SIZE-1:0] a_src [NN];
    logic [DATA_SIZE-1:0] b_src [NN];
    logic [DATA_SIZE-1:0] rows [N][N];
    logic [DATA_SIZE-1:0] cols [N][N];
    logic [DATA_SIZE-1:0] lane_a [N];
    logic [DATA_SIZE-1:0] lane_b [N];

    // The t=0 vector leaves on the start edge itself, before the copies are loaded
    for (genvar e = 0; e < NN; e++) begin : g_src
        assign a_src[e] = (state == IDLE) ? mat_a[e] : a_q[e];
        assign b_src[e] = (state == IDLE) ? mat_b[e] : b_q[e];
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        for (genvar c = 0; c < N; c++) begin : g_elem
            assign rows[i][c] = a_src[i*N+c];
            assign cols[i][c] = b_src[c*N+i];
        end
        feeder_lane #(.N(N), .W(DATA_SIZE), .TW(TW)) u_a (
            .idx(TW'(i)), .t(t_n), .vec(rows[i]), .elem(lane_a[i])
        );
        feeder_lane #(.N(N), .W(DATA_SIZE), .TW(TW)) u_b (
            .idx(TW'(i)), .t(t_n), .vec(cols[i]), .elem(lane_b[i])
        );
    end

    always_comb begin
        state_n = state;
        t_n = t;
        cnt_n = cnt;
        load = 1'b0;
        feed = 1'b0;
        cap = 1'b0;
        err_set = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_n = FEED;
                t_n = '0;
                load = 1'b1;
                feed = 1'b1;
            end
            FEED: if (t == TW'(2 * N - 2)) begin
                state_n = DRAIN;
                cnt_n = '0;
            end else begin
                t_n = t + TW'(1);
                feed = 1'b1;
            end
            DRAIN: if (arr_done) begin
                cap = 1'b1;
                state_n = HOLD;
            end else if (cnt == CW'(DONE_TIMEOUT - 1)) begin
                err_set = 1'b1;
                state_n = IDLE;
            end else begin
                cnt_n = cnt + CW'(1);
            end
            HOLD: if (result_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            t <= '0;
            cnt <= '0;
            busy <= 1'b0;
            arr_reset <= 1'b1;
            arr_a <= '{default: '0};
            arr_b <= '{default: '0};
            result <= '{default: '0};
            result_valid <= 1'b0;
            error <= 1'b0;
        end else begin
            state <= state_n;
            t <= t_n;
            cnt <= cnt_n;
            busy <= state_n != IDLE;
            arr_reset <= state_n == IDLE || state_n == HOLD;
            for (int i = 0; i < N; i++) begin
                arr_a[i] <= feed ? lane_a[i] : '0;
                arr_b[i] <= feed ? lane_b[i] : '0;
            end
            if (cap) result <= arr_result;
            result_valid <= cap || (result_valid && !(state == HOLD && result_ready));
            error <= err_set || (error && !load);
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            a_q <= mat_a;
            b_q <= mat_b;
        end
    end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: directed scoreboard bench with a behavioural systolic array model.
module tb_systolic_feeder;
    import pca_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic result_ready = 1'b1;
    logic done_en = 1'b1;
    elem_t mat_a [16];
    elem_t mat_b [16];
    elem_t arr_a [4];
    elem_t arr_b [4];
    elem_t arr_result [16];
    elem_t result [16];
    logic busy, arr_reset, arr_done, result_valid, error;

    int tests = 0;
    int fails = 0;
    logic [127:0] exp_q [$];

    systolic_feeder dut (
        .clk(clk), .reset(reset), .start(start), .mat_a(mat_a), .mat_b(mat_b),
        .busy(busy), .arr_a(arr_a), .arr_b(arr_b), .arr_reset(arr_reset),
        .arr_done(arr_done), .arr_result(arr_result), .result(result),
        .result_valid(result_valid), .result_ready(result_ready), .error(error)
    );

    always #5 clk = ~clk;

    // Array model: PE(i,j) sees row i delayed by j and column j delayed by i
    int acnt = 0;
    elem_t ha [64][4];
    elem_t hb [64][4];
    assign arr_done = done_en && acnt >= 17;

    function automatic elem_t pe(input int i, input int j);
        elem_t acc = '0;
        for (int tau = 0; tau < 16; tau++)
            if (tau >= i && tau >= j) acc = acc + ha[tau-j][i] * hb[tau-i][j];
        return acc;
    endfunction

    always @(posedge clk) begin
        if (arr_reset) acnt <= 0;
        else begin
            if (acnt < 64)
                for (int l = 0; l < 4; l++) begin
                    ha[acnt][l] <= arr_a[l];
                    hb[acnt][l] <= arr_b[l];
                end
            if (acnt == 16)
                for (int e = 0; e < 16; e++) arr_result[e] <= pe(e / 4, e % 4);
            acnt <= acnt + 1;
        end
    end

    function automatic logic [127:0] pk16(input elem_t m [16]);
        logic [127:0] v;
        for (int k = 0; k < 16; k++) v[8*k+:8] = m[k];
        return v;
    endfunction

    function automatic logic [31:0] pk4(input elem_t m [4]);
        logic [31:0] v;
        for (int k = 0; k < 4; k++) v[8*k+:8] = m[k];
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (result_valid && result_ready) begin
            if (exp_q.size() == 0) chk("sb_unexpected_product", 1, 0);
            else chk("sb_result", pk16(result), exp_q.pop_front());
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic go;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!result_valid && n < 60) begin
            tick();
            n++;
        end
        chk("valid_seen", result_valid, 1);
    endtask

    task automatic set_ident_a(input int scale);
        for (int e = 0; e < 16; e++) mat_a[e] = (e / 4 == e % 4) ? elem_t'(scale) : 8'h00;
    endtask

    task automatic set_seq_b(input int base);
        for (int e = 0; e < 16; e++) mat_b[e] = elem_t'(base + e);
    endtask

    logic [127:0] seq_b, dbl_b, bp_b;
    int n;
    logic seen;

    initial begin
        for (int e = 0; e < 16; e++) begin
            seq_b[8*e+:8] = 8'(e + 1);
            dbl_b[8*e+:8] = 8'(2 * (e + 1));
            bp_b[8*e+:8] = 8'(8'h80 + e);
        end
        set_ident_a(1);
        set_seq_b(1);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        chk("rst_arr_reset", arr_reset, 1);
        chk("rst_busy", busy, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_error", error, 0);
        chk("rst_arr_a", pk4(arr_a), 0);
        chk("rst_result", pk16(result), 0);

        // Identity: result equals B, 18-cycle latency
        tick();
        exp_q.push_back(seq_b);
        go();
        chk("feed_arr_reset", arr_reset, 0);
        chk("feed_busy", busy, 1);
        chk("feed_t0_a", pk4(arr_a), 32'h0000_0001);
        chk("feed_t0_b", pk4(arr_b), 32'h0000_0001);
        for (int e = 0; e < 16; e++) begin
            mat_a[e] = 8'hff;
            mat_b[e] = 8'hff;
        end
        wait_valid(n);
        chk("latency", n, 18);
        tick();
        chk("ident_busy_fall", busy, 0);
        chk("ident_valid_fall", result_valid, 0);

        // Skew of A lanes
        for (int e = 0; e < 16; e++) begin
            mat_a[e] = elem_t'(16 * (e / 4) + e % 4);
            mat_b[e] = 8'h00;
        end
        exp_q.push_back('0);
        go();
        repeat (3) tick();
        chk("skew_t3_a", pk4(arr_a), 32'h3021_1203);
        chk("skew_t3_b", pk4(arr_b), 0);
        repeat (FEED_LEN - 1 - 3) tick();
        chk("skew_t6_a", pk4(arr_a), 32'h3300_0000);
        tick();
        chk("skew_drain_a", pk4(arr_a), 0);
        wait_valid(n);
        tick();

        // Backpressure with ignored start pulses
        set_ident_a(1);
        set_seq_b(8'h80);
        exp_q.push_back(bp_b);
        result_ready = 1'b0;
        go();
        wait_valid(n);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", result_valid, 1);
            chk("bp_result", pk16(result), bp_b);
            chk("bp_arr_reset", arr_reset, 1);
            start = (k == 1 || k == 3);
            tick();
            start = 1'b0;
        end
        chk("bp_valid_end", result_valid, 1);
        result_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("bp_release_valid", result_valid, 0);
        chk("bp_release_busy", busy, 0);
        repeat (2) tick();
        chk("bp_start_dropped", busy, 0);

        // Asynchronous reset mid-FEED, then a fresh product
        set_ident_a(2);
        set_seq_b(1);
        go();
        repeat (2) tick();
        chk("rf_t2_a", pk4(arr_a), 32'h0000_0200);
        #2 reset = 1'b1;
        #1;
        chk("rf_arr_reset", arr_reset, 1);
        chk("rf_busy", busy, 0);
        chk("rf_arr_a", pk4(arr_a), 0);
        chk("rf_arr_b", pk4(arr_b), 0);
        chk("rf_result", pk16(result), 0);
        @(negedge clk) reset = 1'b0;
        tick();
        exp_q.push_back(dbl_b);
        go();
        wait_valid(n);
        chk("rf_latency", n, 18);
        tick();

        // DRAIN timeout
        done_en = 1'b0;
        set_ident_a(1);
        go();
        n = 0;
        seen = 1'b0;
        while (!error && n < 100) begin
            tick();
            n++;
            if (result_valid) seen = 1'b1;
        end
        chk("to_cycles", n, 39);
        chk("to_error", error, 1);
        chk("to_busy", busy, 0);
        chk("to_no_valid", seen, 0);
        chk("to_result_kept", pk16(result), dbl_b);
        done_en = 1'b1;
        exp_q.push_back(seq_b);
        go();
        chk("to_error_clear", error, 0);
        wait_valid(n);
        tick();

        // Overflow truncation
        for (int e = 0; e < 16; e++) begin
            mat_a[e] = 8'h10;
            mat_b[e] = 8'h10;
        end
        exp_q.push_back('0);
        go();
        wait_valid(n);
        tick();
        chk("ovf_error", error, 0);
        chk("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end
endmodule
